// File: rtl/grostl_shift_mix.sv
// Grostl-256 ShiftBytes + iterative MixBytes stage: ShiftBytes is applied when the
// state is captured, then one MixBytes column is produced per clock over eight cycles.
module grostl_shift_mix (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:63][7:0] din,
    input  logic             din_perm_q,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [0:63][7:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_col;
    logic [0:63][7:0] r_work;
    logic [0:63][7:0] r_dout;

    logic [0:63][7:0] w_shift;
    logic [7:0]       w_col_in [0:7];
    logic [7:0]       w_term   [0:7][0:7];
    logic [7:0]       w_mix    [0:7];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by circulant coefficient b[idx], b = 02,02,03,04,05,03,05,07
    function automatic logic [7:0] mul_b(input logic [7:0] x, input logic [2:0] idx);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] res;
        x2 = xtime(x);
        x4 = xtime(x2);
        case (idx)
            3'd0, 3'd1: res = x2;
            3'd2, 3'd5: res = x2 ^ x;
            3'd3:       res = x4;
            3'd4, 3'd6: res = x4 ^ x;
            default:    res = x4 ^ x2 ^ x;
        endcase
        return res;
    endfunction

    // Work byte (row r, col j) takes din byte (row r, col (j + sigma[r]) mod 8)
    genvar gr, gj;
    generate
        for (gr = 0; gr < 8; gr++) begin : g_shift_row
            localparam int SIG_P = gr;
            localparam int SIG_Q = (2 * gr + ((gr < 4) ? 1 : 0)) % 8;
            for (gj = 0; gj < 8; gj++) begin : g_shift_col
                assign w_shift[8 * gj + gr] = din_perm_q ? din[8 * ((gj + SIG_Q) % 8) + gr]
                                                         : din[8 * ((gj + SIG_P) % 8) + gr];
            end
        end
    endgenerate

    genvar gk;
    generate
        for (gk = 0; gk < 8; gk++) begin : g_col_sel
            localparam logic [2:0] KB = 3'(gk);
            assign w_col_in[gk] = r_work[{r_col, KB}];
        end
        for (gr = 0; gr < 8; gr++) begin : g_term_row
            for (gk = 0; gk < 8; gk++) begin : g_term_col
                localparam logic [2:0] IDX = 3'((gk - gr + 8) % 8);
                assign w_term[gr][gk] = mul_b(w_col_in[gk], IDX);
            end
        end
    endgenerate

    always_comb begin
        for (int r = 0; r < 8; r++) begin
            w_mix[r] = 8'h00;
            for (int k = 0; k < 8; k++) begin
                w_mix[r] = w_mix[r] ^ w_term[r][k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_col   <= 3'd0;
            r_work  <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (din_valid) begin
                        r_work  <= w_shift;
                        r_col   <= 3'd0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int r = 0; r < 8; r++) begin
                        r_dout[{r_col, 3'(r)}] <= w_mix[r];
                    end
                    // col parks at 7; only a new capture returns it to 0
                    if (r_col == 3'd7) begin
                        r_state <= DONE;
                    end else begin
                        r_col <= r_col + 3'd1;
                    end
                end
                DONE: begin
                    if (dout_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign din_ready  = (r_state == IDLE);
    assign dout_valid = (r_state == DONE);
    assign dout       = r_dout;

endmodule

// File: tb/tb_grostl_shift_mix.sv
// Bench for grostl_shift_mix: reference ShiftBytes+MixBytes model with a scoreboard,
// plus directed vectors with literal expected results.
module tb_grostl_shift_mix;

    typedef logic [0:63][7:0] st_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    st_t  din = '0;
    logic din_perm_q = 1'b0;
    logic din_valid = 1'b0;
    logic din_ready;
    st_t  dout;
    logic dout_valid;
    logic dout_ready;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    st_t  exp_q[$];
    int   cap_q[$];

    grostl_shift_mix dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_perm_q (din_perm_q),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic st_t ref_model(input st_t d, input logic q);
        int   sp [0:7];
        int   sq [0:7];
        logic [7:0] bv [0:7];
        logic [7:0] sh [0:7][0:7];
        st_t  o;
        sp = '{0, 1, 2, 3, 4, 5, 6, 7};
        sq = '{1, 3, 5, 7, 0, 2, 4, 6};
        bv = '{8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h05, 8'h07};
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                sh[r][j] = d[8 * ((j + (q ? sq[r] : sp[r])) % 8) + r];
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) begin
                o[8 * j + r] = 8'h00;
                for (int k = 0; k < 8; k++)
                    o[8 * j + r] = o[8 * j + r] ^ gmul(bv[(k - r + 8) % 8], sh[k][j]);
            end
        return o;
    endfunction

    function automatic st_t fill(input logic [7:0] v);
        st_t s;
        for (int i = 0; i < 64; i++) s[i] = v;
        return s;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int i = 0; i < 64; i++) s[i] = 8'($urandom);
        return s;
    endfunction

    task automatic chk(input string name, input st_t act, input st_t expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, expv);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%b exp=%b", name, act, expv);
        end
    endtask

    task automatic send(input st_t d, input logic q, input logic hold);
        int n;
        n = 0;
        @(negedge clk);
        din = d;
        din_perm_q = q;
        din_valid = 1'b1;
        while (!din_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk_bit("send_timeout", (n < 2000), 1'b1);
        @(negedge clk);
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic wait_result(output st_t got);
        int n;
        n = 0;
        while (!dout_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_bit("result_timeout", dout_valid, 1'b1);
        got = dout;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk_bit("idle_timeout", (exp_q.size() == 0), 1'b1);
    endtask

    task automatic directed(input string name, input st_t d, input logic q, input st_t expv);
        st_t got;
        send(d, q, 1'b0);
        wait_result(got);
        chk(name, got, expv);
        $display("txn %s q=%0d dout[0:7]=%h", name, q, got[0:7]);
        wait_idle();
    endtask

    initial begin
        st_t e;
        st_t got;
        st_t imp_in;
        logic [7:0] imp [0:7];
        imp = '{8'h02, 8'h07, 8'h05, 8'h03, 8'h05, 8'h04, 8'h03, 8'h02};

        fork
            // scoreboard: sample 1 ns before each rising edge, apply at the edge
            forever begin
                logic cap_now;
                logic hs_now;
                st_t  m;
                @(negedge clk);
                #4;
                cap_now = rst_n && din_valid && din_ready;
                hs_now  = rst_n && dout_valid && dout_ready;
                m = ref_model(din, din_perm_q);
                @(posedge clk);
                cyc++;
                if (hs_now && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(cap_q.pop_front());
                end
                if (cap_now) begin
                    exp_q.push_back(m);
                    cap_q.push_back(cyc);
                end
            end
            forever begin
                @(negedge rst_n);
                exp_q.delete();
                cap_q.delete();
            end
            forever begin
                @(negedge clk);
                #1;
                case (rdy_mode)
                    0:       dout_ready = 1'b1;
                    1:       dout_ready = ($urandom_range(0, 3) != 0);
                    default: dout_ready = 1'b0;
                endcase
            end
            // per-cycle compare against the scoreboard
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk_bit("din_ready", din_ready, (exp_q.size() == 0));
                    if (exp_q.size() > 0) begin
                        chk_bit("dout_valid_latency", dout_valid, ((cyc - cap_q[0]) >= 8));
                        if (dout_valid) chk("dout_model", dout, exp_q[0]);
                    end else begin
                        chk_bit("spurious_valid", dout_valid, 1'b0);
                    end
                end
            end
            begin
                #5_000_000;
                $display("FAIL watchdog act=timeout exp=finish");
                $fatal(1, "watchdog");
            end
        join_none

        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, '0);
        chk_bit("reset_din_ready", din_ready, 1'b1);
        chk_bit("reset_dout_valid", dout_valid, 1'b0);
        #2 rst_n = 1'b1;

        directed("zero_p", fill(8'h00), 1'b0, fill(8'h00));
        directed("ones_p", fill(8'h01), 1'b0, fill(8'h03));
        directed("x80_q", fill(8'h80), 1'b1, fill(8'h9B));

        imp_in = '0;
        imp_in[0] = 8'h01;
        e = '0;
        for (int r = 0; r < 8; r++) e[r] = imp[r];
        directed("impulse_p", imp_in, 1'b0, e);
        e = '0;
        for (int r = 0; r < 8; r++) e[56 + r] = imp[r];
        directed("impulse_q", imp_in, 1'b1, e);

        // backpressure with din_valid held high throughout
        rdy_mode = 2;
        send(rand_state(), 1'b0, 1'b1);
        wait_result(got);
        repeat (5) begin
            @(negedge clk);
            chk("stall_stable", dout, got);
            chk_bit("stall_valid", dout_valid, 1'b1);
        end
        rdy_mode = 0;
        @(negedge clk);
        chk_bit("post_hs_din_ready", din_ready, 1'b1);
        din_valid = 1'b0;
        $display("txn backpressure dout[0:7]=%h", got[0:7]);
        wait_idle();

        // reset while BUSY at col=3
        send(rand_state(), 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("midrst_dout_valid", dout_valid, 1'b0);
        chk_bit("midrst_din_ready", din_ready, 1'b1);
        chk("midrst_dout", dout, '0);
        $display("txn reset_mid_busy dout_valid=%b din_ready=%b", dout_valid, din_ready);
        @(negedge clk);
        #2 rst_n = 1'b1;
        e = '0;
        for (int r = 0; r < 8; r++) e[r] = imp[r];
        directed("after_reset_p", imp_in, 1'b0, e);

        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            st_t s;
            logic q;
            s = rand_state();
            q = 1'($urandom_range(0, 1));
            send(s, q, 1'b0);
            if (i % 100 == 0) $display("txn random %0d q=%0d din[0:7]=%h", i, q, s[0:7]);
        end
        wait_idle();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
